multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 4: width of the memory-wait counter; timeout after 2**TIMEOUT_W-1 wait cycles.
REQ-002 SHALL have parameter IALU_EN, default 1: 1 = I-type ALU opcode 0010011 is legal, 0 = it traps.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 7: instruction[6:0] from the instruction register, sampled in DECODE only.
REQ-006 SHALL have port mem_ready, input, 1: memory completes the current request this cycle.
REQ-007 SHALL have port mem_req, output, 1: memory request active.
REQ-008 SHALL have port mem_we, output, 1: request is a write.
REQ-009 SHALL have port i_or_d, output, 1: address select (0 = PC, 1 = ALU result).
REQ-010 SHALL have port ir_write, output, 1: load the instruction register.
REQ-011 SHALL have port pc_write, output, 1: PC <= PC+4.
REQ-012 SHALL have port alu_src_a, output, 1: 0 = PC, 1 = rs1.
REQ-013 SHALL have port alu_src_b, output, 2: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-014 SHALL have port alu_op, output, 2: 00 = add, 01 = compare/branch, 10 = funct-decoded.
REQ-015 SHALL have ports reg_write, mem_to_reg, branch, output, 1 each: register-file write, write-back from memory, branch-resolve strobe.
REQ-016 SHALL have port instr_done, output, 1: one-cycle pulse in the final cycle of each instruction.
REQ-017 SHALL have port trap, output, 1: sticky error flag.
REQ-018 SHALL have port trap_cause, output, 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.
REQ-019 SHALL have port state_dbg, output, 4: current state encoding.

Function
REQ-020 SHALL implement states FETCH=0, DECODE=1, ADDR=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, WB_ALU=8, BRANCH=9, TRAP=15.
REQ-021 FETCH SHALL assert mem_req with i_or_d=0 and hold until mem_ready; in the mem_ready cycle it SHALL assert ir_write, pc_write, alu_src_a=0, alu_src_b=01 and alu_op=00, then move to DECODE.
REQ-022 DECODE SHALL route by opcode: 0110011->EXEC_R; 0010011->EXEC_I (IALU_EN=1, else TRAP); 0000011 and 0100011->ADDR; 1100011->BRANCH; any other value, including 0000000->TRAP with cause 01.
REQ-023 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=10; both SHALL then move to WB_ALU.
REQ-024 WB_ALU SHALL assert reg_write with mem_to_reg=0 and instr_done, then move to FETCH.
REQ-025 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; it SHALL then move to MEM_RD for a load or MEM_WR for a store, using the opcode class latched in DECODE.
REQ-026 MEM_RD SHALL assert mem_req with i_or_d=1 until mem_ready, then move to WB_MEM.
REQ-027 WB_MEM SHALL assert reg_write, mem_to_reg and instr_done, then move to FETCH.
REQ-028 MEM_WR SHALL assert mem_req, mem_we and i_or_d=1 until mem_ready; in the mem_ready cycle it SHALL assert instr_done, then move to FETCH.
REQ-029 BRANCH SHALL assert branch and instr_done with alu_src_a=1, alu_src_b=00, alu_op=01 for exactly one cycle, then move to FETCH.
REQ-030 The wait counter SHALL clear on entering any memory state and increment each cycle mem_req=1 and mem_ready=0.
REQ-031 When the wait counter reaches 2**TIMEOUT_W-1 with mem_ready still low, the block SHALL enter TRAP with cause 10.
REQ-032 If mem_ready arrives in the same cycle the limit is reached, the completion SHALL win and no trap SHALL occur.
REQ-033 TRAP SHALL hold trap=1, deassert all other strobes and remain in TRAP until rst.
REQ-034 All outputs not listed for a state SHALL be 0.
REQ-035 Outputs SHALL be decoded from state, plus mem_ready for the completion strobes only; there SHALL be no other combinational input-to-output paths.

Reset
REQ-036 On rst=1 at a clock edge: state=FETCH, wait counter=0, trap=0, trap_cause=00, latched opcode class cleared.
REQ-037 Reset SHALL override every state, including a pending memory request and TRAP.
REQ-038 The first mem_req SHALL assert in the first cycle after rst falls.

Structure
REQ-039 A shared package mc_ctrl_pkg SHALL hold the opcode constants, state encodings, alu_op, alu_src_b and trap_cause encodings.
REQ-040 A combinational sub-module mc_opcode_class SHALL map opcode and IALU_EN to a class plus an illegal flag; it is the only opcode decoder in the block.

Verification
REQ-041 Reset, then run R-type (0110011) with mem_ready=1 every cycle -> states 0,1,6,8,0; instr_done high in cycle 4; reg_write=1, mem_to_reg=0.
REQ-042 Load (0000011) with 2 wait cycles in both FETCH and MEM_RD -> 0(x3),1,2,3(x3),4; mem_to_reg=1 in WB_MEM.
REQ-043 Store (0100011) -> mem_we=1 only in MEM_WR; reg_write never 1; instr_done on the mem_ready cycle.
REQ-044 Opcode 0000000, and 0010011 with IALU_EN=0 -> TRAP, trap_cause=01, trap stays high 20 cycles; rst returns state to FETCH.
REQ-045 TIMEOUT_W=2 with mem_ready held low in FETCH -> TRAP after 3 wait cycles, cause 10; mem_ready rising on the 3rd wait cycle -> DECODE, no trap.
REQ-046 Assert rst during MEM_RD wait -> next cycle state=FETCH, mem_req=1, i_or_d=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle controller.
//   - RV32 base opcodes recognised by the controller
//   - FSM state encodings (also visible on state_dbg)
//   - alu_op, alu_src_b and trap_cause encodings
//   - opcode class produced by mc_opcode_class
package mc_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_ADDR   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_WB_MEM = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_EXEC_I = 4'd7,
    ST_WB_ALU = 4'd8,
    ST_BRANCH = 4'd9,
    ST_TRAP   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: memory request handshake between the controller
// and the memory port.
//   mem_req   - request active (controller -> memory)
//   mem_we    - request is a write (controller -> memory)
//   i_or_d    - address select, 0 = PC, 1 = ALU result (controller -> memory)
//   mem_ready - memory completes the current request this cycle (memory -> controller)
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational opcode decoder; the only one in the block.
//   opcode   - instruction[6:0]
//   op_class - instruction class (CLS_NONE when illegal)
//   illegal  - opcode is not supported (I-type ALU is illegal when IALU_EN = 0)
module mc_opcode_class
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned IALU_EN = 1
) (
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_R:      op_class = CLS_R;
      OPC_I: begin
        if (IALU_EN != 0) op_class = CLS_I;
        else              illegal  = 1'b1;
      end
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      default:    illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RISC-V datapath controller FSM.
//   clk, rst      - clock, synchronous active-high reset
//   opcode        - instruction[6:0], used in DECODE only
//   mem           - memory handshake (mem_req, mem_we, i_or_d, mem_ready)
//   ir_write, pc_write, alu_src_a, alu_src_b, alu_op,
//   reg_write, mem_to_reg, branch - datapath controls
//   instr_done    - pulse in the final cycle of each instruction
//   trap, trap_cause - sticky error flag and its reason
//   state_dbg     - current state encoding
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned IALU_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 opcode,
  multicycle_control_if.master       mem,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       alu_src_a,
  output logic [1:0]                 alu_src_b,
  output logic [1:0]                 alu_op,
  output logic                       reg_write,
  output logic                       mem_to_reg,
  output logic                       branch,
  output logic                       instr_done,
  output logic                       trap,
  output logic [1:0]                 trap_cause,
  output logic [3:0]                 state_dbg
);

  // The wait that would take the counter to all-ones is the last one allowed.
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = WAIT_MAX - TIMEOUT_W'(1);

  state_t                state, state_nxt;
  trap_cause_t           cause_q, cause_nxt;
  op_class_t             cls_q, op_class;
  logic                  illegal;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  limit_hit;

  mc_opcode_class #(.IALU_EN(IALU_EN)) u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class),
    .illegal  (illegal)
  );

  assign limit_hit  = (wait_cnt == WAIT_LAST);
  assign state_dbg  = state;
  assign trap_cause = cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      cause_q <= CAUSE_NONE;
      cls_q   <= CLS_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == ST_DECODE) cls_q <= op_class;
    end
  end

  // Clearing on every state change covers entry into each memory state,
  // since memory states only self-loop while waiting.
  always_ff @(posedge clk) begin
    if (rst)                                 wait_cnt <= '0;
    else if (state_nxt != state)             wait_cnt <= '0;
    else if (mem.mem_req && !mem.mem_ready)  wait_cnt <= wait_cnt + TIMEOUT_W'(1);
  end

  always_comb begin
    state_nxt   = state;
    cause_nxt   = cause_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.i_or_d  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    instr_done  = 1'b0;
    trap        = 1'b0;

    case (state)
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          state_nxt = ST_DECODE;
        end else if (limit_hit) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          case (op_class)
            CLS_R:                state_nxt = ST_EXEC_R;
            CLS_I:                state_nxt = ST_EXEC_I;
            CLS_LOAD, CLS_STORE:  state_nxt = ST_ADDR;
            CLS_BRANCH:           state_nxt = ST_BRANCH;
            default: begin
              state_nxt = ST_TRAP;
              cause_nxt = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (cls_q == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) begin
          state_nxt = ST_WB_MEM;
        end else if (limit_hit) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end else if (limit_hit) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
        state_nxt = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_nxt = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_BRANCH: begin
        branch     = 1'b1;
        instr_done = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_CMP;
        state_nxt  = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_nxt = ST_TRAP;
      end
    endcase
  end

endmodule
